// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit and its ALU decoder.
// MC_CTRL_BRANCH_EXT_EN widens the legal branch funct3 set beyond beq.
package mc_pkg;

  localparam int unsigned STATE_W    = 4;
  localparam int unsigned OP_W       = 7;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned FLAGS_W    = 4;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned SEL_W      = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    JAL      = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BR  = 7'b1100011;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

  localparam logic [SEL_W-1:0] SRC_A_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEMDATA = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;
  localparam logic [SEL_W-1:0] IMM_I       = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S       = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B       = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J       = 2'b11;

  // Flag bit positions within {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic branch_legal(input logic [F3_W-1:0] f3);
`ifdef MC_CTRL_BRANCH_EXT_EN
    return (f3 != 3'b010) && (f3 != 3'b011);
`else
    return f3 == 3'b000;
`endif
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bus between the control unit (master) and the datapath (slave).
interface mc_control_unit_if;
  import mc_pkg::*;

  logic [OP_W-1:0]       op;
  logic [F3_W-1:0]       funct3;
  logic                  funct7b5;
  logic [FLAGS_W-1:0]    flags;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [SEL_W-1:0]      alu_src_a;
  logic [SEL_W-1:0]      alu_src_b;
  logic [SEL_W-1:0]      result_src;
  logic [SEL_W-1:0]      imm_src;
  logic                  adr_src;
  logic                  ir_write;
  logic                  pc_write;
  logic                  mem_write;
  logic                  reg_write;
  logic                  illegal_instr;
  logic [STATE_W-1:0]    state;

  modport master (
    input  op, funct3, funct7b5, flags,
    output alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
           ir_write, pc_write, mem_write, reg_write, illegal_instr, state
  );

  modport slave (
    output op, funct3, funct7b5, flags,
    input  alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
           ir_write, pc_write, mem_write, reg_write, illegal_instr, state
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// Maps alu_op plus instruction function bits to the ALU control code; flags unsupported funct3.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  alu_op_t               alu_op,
  input  logic [F3_W-1:0]       funct3,
  input  logic                  op5,
  input  logic                  funct7b5,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: funct_illegal = 1'b0;
      default:                        funct_illegal = 1'b1;
    endcase
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I-subset control FSM driving datapath selects/strobes and the ALU control code.
// MC_CTRL_BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu resolution in the branch state.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input logic                clk,
  input logic                reset,
  mc_control_unit_if.master  bus
);

  state_t  state_q;
  state_t  state_d;
  state_t  out_state;
  alu_op_t alu_op;
  logic    funct_illegal;
  logic    take;
  logic    pc_update;
  logic    branch;
  logic    ir_en;
  logic    mem_en;
  logic    reg_en;

  mc_alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct3        (bus.funct3),
    .op5           (bus.op[5]),
    .funct7b5      (bus.funct7b5),
    .alu_control   (bus.alu_control),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = funct_illegal ? TRAP : EXECUTER;
          OP_I:         state_d = funct_illegal ? TRAP : EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BR:        state_d = branch_legal(bus.funct3) ? BEQ : TRAP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      TRAP:     state_d = ILLEGAL_TRAP ? TRAP : FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Branch condition from ALU flags of rs1 - rs2
  always_comb begin
    take = 1'b0;
`ifdef MC_CTRL_BRANCH_EXT_EN
    case (bus.funct3)
      3'b000:  take = bus.flags[FLAG_Z];
      3'b001:  take = ~bus.flags[FLAG_Z];
      3'b100:  take = bus.flags[FLAG_N] ^ bus.flags[FLAG_V];
      3'b101:  take = ~(bus.flags[FLAG_N] ^ bus.flags[FLAG_V]);
      3'b110:  take = ~bus.flags[FLAG_C];
      3'b111:  take = bus.flags[FLAG_C];
      default: take = 1'b0;
    endcase
`else
    take = bus.flags[FLAG_Z];
`endif
  end

  // Moore outputs; reset presents FETCH selects with every strobe suppressed
  always_comb begin
    out_state      = reset ? FETCH : state_q;
    alu_op         = ALU_OP_ADD;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.result_src = RES_ALUOUT;
    bus.imm_src    = IMM_I;
    bus.adr_src    = 1'b0;
    pc_update      = 1'b0;
    branch         = 1'b0;
    ir_en          = 1'b0;
    mem_en         = 1'b0;
    reg_en         = 1'b0;
    case (out_state)
      FETCH: begin
        ir_en = 1'b1; bus.alu_src_b = SRC_B_FOUR;
        bus.result_src = RES_ALU; pc_update = 1'b1;
      end
      DECODE: begin
        bus.alu_src_a = SRC_A_OLDPC; bus.alu_src_b = SRC_B_IMM; bus.imm_src = IMM_B;
      end
      MEMADR: begin
        bus.alu_src_a = SRC_A_RS1; bus.alu_src_b = SRC_B_IMM;
        bus.imm_src = (bus.op == OP_SW) ? IMM_S : IMM_I;
      end
      MEMREAD:  bus.adr_src = 1'b1;
      MEMWB: begin
        bus.result_src = RES_MEMDATA; reg_en = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src = 1'b1; mem_en = 1'b1;
      end
      EXECUTER: begin
        bus.alu_src_a = SRC_A_RS1; alu_op = ALU_OP_FUNCT;
      end
      EXECUTEI: begin
        bus.alu_src_a = SRC_A_RS1; bus.alu_src_b = SRC_B_IMM; alu_op = ALU_OP_FUNCT;
      end
      JAL: begin
        bus.alu_src_a = SRC_A_OLDPC; bus.alu_src_b = SRC_B_FOUR;
        pc_update = 1'b1; bus.imm_src = IMM_J;
      end
      ALUWB: reg_en = 1'b1;
      BEQ: begin
        bus.alu_src_a = SRC_A_RS1; alu_op = ALU_OP_SUB; branch = 1'b1;
      end
      default: ;
    endcase
    bus.ir_write      = ir_en & ~reset;
    bus.mem_write     = mem_en & ~reset;
    bus.reg_write     = reg_en & ~reset;
    bus.pc_write      = (pc_update | (branch & take)) & ~reset;
    bus.illegal_instr = (out_state == TRAP);
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench: per-instruction expected cycle sequences from an instruction-level model.
module tb_mc_control_unit;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] ac;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [1:0] imm;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       mw;
    logic       rw;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic       f7b5 = 1'b0;
  logic [3:0] flags = 4'd0;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];

  mc_control_unit_if bus1();
  mc_control_unit_if bus0();

  assign bus1.op = op;       assign bus0.op = op;
  assign bus1.funct3 = f3;   assign bus0.funct3 = f3;
  assign bus1.funct7b5 = f7b5; assign bus0.funct7b5 = f7b5;
  assign bus1.flags = flags; assign bus0.flags = flags;

  mc_control_unit #(.ILLEGAL_TRAP(1'b1)) dut    (.clk(clk), .reset(reset), .bus(bus1));
  mc_control_unit #(.ILLEGAL_TRAP(1'b0)) dut_nt (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic exp_t obs();
    return {bus1.state, bus1.alu_control, bus1.alu_src_a, bus1.alu_src_b, bus1.result_src,
            bus1.imm_src, bus1.adr_src, bus1.ir_write, bus1.pc_write, bus1.mem_write,
            bus1.reg_write, bus1.illegal_instr};
  endfunction

  // ---- reference model: instruction semantics -> per-cycle control expectations ----
  function automatic logic [2:0] alu_fn();
    case (f3)
      3'b000:  return (op == 7'b0110011 && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic br_take();
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (f3)
      3'b000: return z;
`ifdef MC_CTRL_BRANCH_EXT_EN
      3'b001: return !z;
      3'b100: return n != v;
      3'b101: return n == v;
      3'b110: return !c;
      3'b111: return c;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit instr_legal();
    case (op)
      7'b0000011, 7'b0100011, 7'b1101111: return 1;
      7'b0110011, 7'b0010011: return f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
`ifdef MC_CTRL_BRANCH_EXT_EN
      7'b1100011: return !(f3 inside {3'b010, 3'b011});
`else
      7'b1100011: return f3 == 3'b000;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic exp_t phase(input state_t s);
    exp_t e = '0;
    e.st = 4'(s);
    case (s)
      FETCH:    begin e.irw = 1; e.b = 2'b10; e.rs = 2'b10; e.pcw = 1; end
      DECODE:   begin e.a = 2'b01; e.b = 2'b01; e.imm = 2'b10; end
      MEMADR:   begin e.a = 2'b10; e.b = 2'b01; e.imm = (op == 7'b0100011) ? 2'b01 : 2'b00; end
      MEMREAD:  e.adr = 1;
      MEMWB:    begin e.rs = 2'b01; e.rw = 1; end
      MEMWRITE: begin e.adr = 1; e.mw = 1; end
      EXECUTER: begin e.a = 2'b10; e.ac = alu_fn(); end
      EXECUTEI: begin e.a = 2'b10; e.b = 2'b01; e.ac = alu_fn(); end
      JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1; e.imm = 2'b11; end
      ALUWB:    e.rw = 1;
      BEQ:      begin e.a = 2'b10; e.ac = 3'b001; e.pcw = br_take(); end
      TRAP:     e.ill = 1;
      default:  ;
    endcase
    return e;
  endfunction

  function automatic void build_seq();
    exp_q.delete();
    exp_q.push_back(phase(FETCH));
    exp_q.push_back(phase(DECODE));
    if (!instr_legal()) begin
      exp_q.push_back(phase(TRAP));
      return;
    end
    case (op)
      7'b0000011: begin exp_q.push_back(phase(MEMADR)); exp_q.push_back(phase(MEMREAD));
                        exp_q.push_back(phase(MEMWB)); end
      7'b0100011: begin exp_q.push_back(phase(MEMADR)); exp_q.push_back(phase(MEMWRITE)); end
      7'b0110011: begin exp_q.push_back(phase(EXECUTER)); exp_q.push_back(phase(ALUWB)); end
      7'b0010011: begin exp_q.push_back(phase(EXECUTEI)); exp_q.push_back(phase(ALUWB)); end
      7'b1101111: begin exp_q.push_back(phase(JAL)); exp_q.push_back(phase(ALUWB)); end
      default:    exp_q.push_back(phase(BEQ));
    endcase
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] fn3, input logic b5,
                           input logic [3:0] fl);
    op = o; f3 = fn3; f7b5 = b5; flags = fl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus1.state !== 4'(FETCH) || bus1.ir_write !== 1'b0 || bus1.pc_write !== 1'b0 ||
        bus1.alu_src_b !== 2'b10) begin
      errors++;
      $display("FAIL reset_state: state=%0d ir_write=%b pc_write=%b b=%b, want state=%0d 0 0 10",
               bus1.state, bus1.ir_write, bus1.pc_write, bus1.alu_src_b, FETCH);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_alu();
    logic [6:0] ops[3] = '{7'b0110011, 7'b0110011, 7'b0010011};
    for (int t = 0; t < 3; t++) begin
      set_instr(ops[t], 3'b000, (t != 0), 4'($urandom));
      build_seq();
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs() !== exp_q[i]) begin
          errors++;
          $display("FAIL alu[%0d] cycle %0d: got %h want %h", t, i, obs(), exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_mem();
    for (int t = 0; t < 2; t++) begin
      set_instr((t == 0) ? 7'b0000011 : 7'b0100011, 3'b010, 1'b0, 4'($urandom));
      build_seq();
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs() !== exp_q[i]) begin
          errors++;
          $display("FAIL mem[%0d] cycle %0d: got %h want %h", t, i, obs(), exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] fns[3] = '{3'b000, 3'b000, 3'b100};
    logic [3:0] fls[3] = '{4'b0100, 4'b0000, 4'b1000};
    for (int t = 0; t < 3; t++) begin
      set_instr(7'b1100011, fns[t], 1'b0, fls[t]);
      build_seq();
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs() !== exp_q[i]) begin
          errors++;
          $display("FAIL branch[%0d] cycle %0d: got %h want %h", t, i, obs(), exp_q[i]);
        end
        @(posedge clk); #1;
      end
      if (!instr_legal()) do_reset();
    end
  endtask

  task automatic test_trap();
    set_instr(7'b1111111, 3'($urandom), 1'($urandom), 4'($urandom));
    build_seq();
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL trap cycle %0d: got %h want %h", i, obs(), exp_q[i]);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus1.state !== 4'(TRAP) || bus1.illegal_instr !== 1'b1 || bus1.pc_write !== 1'b0) begin
        errors++;
        $display("FAIL trap_hold[%0d]: state=%0d ill=%b pcw=%b want state=%0d ill=1 pcw=0",
                 k, bus1.state, bus1.illegal_instr, bus1.pc_write, TRAP);
      end
      if (k == 0) begin
        checks++;
        if (bus0.state !== 4'(FETCH) || bus0.ir_write !== 1'b1) begin
          errors++;
          $display("FAIL trap_nop_exit: state=%0d ir_write=%b want state=%0d ir_write=1",
                   bus0.state, bus0.ir_write, FETCH);
        end
      end
      @(posedge clk); #1;
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (bus1.state !== 4'(FETCH) || bus1.illegal_instr !== 1'b0) begin
      errors++;
      $display("FAIL trap_reset_exit: state=%0d ill=%b want state=%0d ill=0",
               bus1.state, bus1.illegal_instr, FETCH);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_reset_midop();
    set_instr(7'b0000011, 3'b010, 1'b0, 4'd0);
    build_seq();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_midop cycle %0d: got %h want %h", i, obs(), exp_q[i]);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.ir_write !== 1'b0 || bus1.mem_write !== 1'b0 || bus1.reg_write !== 1'b0 ||
        bus1.pc_write !== 1'b0 || bus1.adr_src !== 1'b0 || bus1.alu_src_b !== 2'b10) begin
      errors++;
      $display("FAIL reset_in_memread: irw=%b mw=%b rw=%b pcw=%b adr=%b b=%b want 0 0 0 0 0 10",
               bus1.ir_write, bus1.mem_write, bus1.reg_write, bus1.pc_write, bus1.adr_src,
               bus1.alu_src_b);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus1.state !== 4'(FETCH) || bus1.ir_write !== 1'b0 || bus1.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_next_state: state=%0d irw=%b rw=%b want state=%0d 0 0",
               bus1.state, bus1.ir_write, bus1.reg_write, FETCH);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] legal_ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1101111, 7'b1100011};
    logic [6:0] bad_ops[3]   = '{7'b1111111, 7'b0000000, 7'b1110011};
    for (int n = 0; n < 80; n++) begin
      int unsigned k = $urandom_range(0, 7);
      logic [6:0] o = (k < 6) ? legal_ops[k] : bad_ops[$urandom_range(0, 2)];
      set_instr(o, 3'($urandom), 1'($urandom), 4'($urandom));
      build_seq();
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs() !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b[%0d] op=%b f3=%b cycle %0d: got %h want %h",
                   n, op, f3, i, obs(), exp_q[i]);
        end
        @(posedge clk); #1;
      end
      if (!instr_legal()) begin
        @(negedge clk);
        checks++;
        if (bus1.state !== 4'(TRAP) || bus0.state !== 4'(FETCH)) begin
          errors++;
          $display("FAIL b2b_trap[%0d]: sticky=%0d nop=%0d want sticky=%0d nop=%0d",
                   n, bus1.state, bus0.state, TRAP, FETCH);
        end
        @(posedge clk); #1;
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_trap();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
